// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-scheduling engine.
package rc4_pkg;
  localparam int S_SIZE     = 256;
  localparam int KEY_BYTE_W = 8;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FILL   = 4'd1,
    RD_I   = 4'd2,
    WAIT_I = 4'd3,
    CALC_J = 4'd4,
    RD_J   = 4'd5,
    WAIT_J = 4'd6,
    WR_J   = 4'd7,
    WR_I   = 4'd8,
    DONE   = 4'd9
  } ksa_state_e;
endpackage

// File: rtl/rc4_ksa_engine_key_byte_sel.sv
// Selects key byte idx from a packed key whose byte 0 sits in the top bits.
module key_byte_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int IDX_W     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
  input  logic [KEY_BYTE_W*KEY_BYTES-1:0] key,
  input  logic [IDX_W-1:0]                idx,
  output logic [KEY_BYTE_W-1:0]           key_byte
);

  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (idx == IDX_W'(k)) begin
        key_byte = key[KEY_BYTE_W*(KEY_BYTES-k)-1 -: KEY_BYTE_W];
      end
    end
  end

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: optional identity fill of S, then the 256-step
// swap shuffle against an external S-RAM with fixed read latency RD_LAT.
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int  KEY_BYTES = 3,
  parameter int  RD_LAT    = 2,
  parameter int  INIT_EN   = 1,
  localparam int KEY_W     = KEY_BYTE_W * KEY_BYTES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [KEY_W-1:0] secret_key,
  input  logic [7:0]       q,
  output logic [7:0]       address,
  output logic [7:0]       data,
  output logic             wren,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output ksa_state_e       dbg_state
);

  localparam int         KIW      = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
  localparam logic [KIW-1:0] KIDX_LAST = KIW'(KEY_BYTES - 1);

  ksa_state_e     state_q, state_d;
  logic [7:0]     i_q, i_d;
  logic [7:0]     j_q, j_d;
  logic [7:0]     si_q, si_d;
  logic [7:0]     sj_q, sj_d;
  logic [KIW-1:0] kidx_q, kidx_d;
  logic [1:0]     wcnt_q, wcnt_d;
  logic [7:0]     address_q, address_d;
  logic [7:0]     data_q, data_d;
  logic           wren_q, wren_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           aborted_q, aborted_d;
  logic [7:0]     key_byte;

  key_byte_sel #(
    .KEY_BYTES (KEY_BYTES),
    .IDX_W     (KIW)
  ) u_key_byte_sel (
    .key      (secret_key),
    .idx      (kidx_q),
    .key_byte (key_byte)
  );

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    si_d      = si_q;
    sj_d      = sj_q;
    kidx_d    = kidx_q;
    wcnt_d    = wcnt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          state_d = (INIT_EN != 0) ? FILL : RD_I;
        end
      end
      // i doubles as the fill counter and is cleared before the shuffle.
      FILL: begin
        if (i_q == 8'hFF) begin
          i_d     = '0;
          state_d = RD_I;
        end else begin
          i_d = i_q + 8'd1;
        end
      end
      RD_I: begin
        wcnt_d  = '0;
        state_d = WAIT_I;
      end
      WAIT_I: begin
        if (wcnt_q == LAT_LAST) begin
          si_d    = q;
          state_d = CALC_J;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      CALC_J: begin
        j_d     = j_q + si_q + key_byte;
        state_d = RD_J;
      end
      RD_J: begin
        wcnt_d  = '0;
        state_d = WAIT_J;
      end
      WAIT_J: begin
        if (wcnt_q == LAT_LAST) begin
          sj_d    = q;
          state_d = WR_J;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      WR_J: state_d = WR_I;
      WR_I: begin
        if (i_q == 8'hFF) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + KIW'(1);
          state_d = RD_I;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end

    // Bus outputs are registered, so they are derived from the next state.
    address_d = '0;
    data_d    = '0;
    wren_d    = 1'b0;
    case (state_d)
      FILL: begin
        address_d = i_d;
        data_d    = i_d;
        wren_d    = 1'b1;
      end
      RD_I, WAIT_I, CALC_J: address_d = i_d;
      RD_J, WAIT_J:         address_d = j_d;
      WR_J: begin
        address_d = j_d;
        data_d    = si_d;
        wren_d    = 1'b1;
      end
      WR_I: begin
        address_d = i_d;
        data_d    = sj_d;
        wren_d    = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      si_q      <= '0;
      sj_q      <= '0;
      kidx_q    <= '0;
      wcnt_q    <= '0;
      address_q <= '0;
      data_q    <= '0;
      wren_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      kidx_q    <= kidx_d;
      wcnt_q    <= wcnt_d;
      address_q <= address_d;
      data_q    <= data_d;
      wren_q    <= wren_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign address   = address_q;
  assign data      = data_q;
  assign wren      = wren_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: three configurations, each with its own S-RAM model.
module tb_rc4_ksa_engine;
  import rc4_pkg::*;

  // Engine a: "Key", RD_LAT=2, fill on. b: 5-byte key, RD_LAT=1. c: 1-byte zero key, RD_LAT=3, no fill.
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;
  localparam int LAT_C = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic preload_c = 1'b0;

  logic        start_a = 1'b0, abort_a = 1'b0;
  logic        start_b = 1'b0, abort_b = 1'b0;
  logic        start_c = 1'b0, abort_c = 1'b0;
  logic [23:0] key_a = 24'h4B6579;
  logic [39:0] key_b = 40'h0102030405;
  logic [7:0]  key_c = 8'h00;
  logic [7:0]  q_a, q_b, q_c;
  logic [7:0]  address_a, address_b, address_c;
  logic [7:0]  data_a, data_b, data_c;
  logic        wren_a, wren_b, wren_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        aborted_a, aborted_b, aborted_c;
  ksa_state_e  dbg_state_a, dbg_state_b, dbg_state_c;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] mem_c [256];
  logic [7:0] pipe_a [3];
  logic [7:0] pipe_b [3];
  logic [7:0] pipe_c [3];

  int wr_cnt_a = 0, wr_cnt_b = 0, wr_cnt_c = 0;
  int done_cnt_a = 0;
  int eq_cnt_c = 0;
  logic       prev_wren_c = 1'b0;
  logic [7:0] prev_addr_c = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] model_s [256];
  int         model_eq;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  rc4_ksa_engine #(.KEY_BYTES(3), .RD_LAT(LAT_A), .INIT_EN(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .secret_key(key_a),
    .q(q_a), .address(address_a), .data(data_a), .wren(wren_a), .busy(busy_a),
    .done(done_a), .aborted(aborted_a), .dbg_state(dbg_state_a));

  rc4_ksa_engine #(.KEY_BYTES(5), .RD_LAT(LAT_B), .INIT_EN(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .secret_key(key_b),
    .q(q_b), .address(address_b), .data(data_b), .wren(wren_b), .busy(busy_b),
    .done(done_b), .aborted(aborted_b), .dbg_state(dbg_state_b));

  rc4_ksa_engine #(.KEY_BYTES(1), .RD_LAT(LAT_C), .INIT_EN(0)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .abort(abort_c), .secret_key(key_c),
    .q(q_c), .address(address_c), .data(data_c), .wren(wren_c), .busy(busy_c),
    .done(done_c), .aborted(aborted_c), .dbg_state(dbg_state_c));

  // ---------------- S-RAM models ----------------
  always @(posedge clk) begin
    if (wren_a) mem_a[address_a] <= data_a;
    pipe_a[0] <= mem_a[address_a];
    pipe_a[1] <= pipe_a[0];
    pipe_a[2] <= pipe_a[1];
    if (wren_a) wr_cnt_a <= wr_cnt_a + 1;
    if (done_a) done_cnt_a <= done_cnt_a + 1;
  end
  assign q_a = pipe_a[LAT_A-1];

  always @(posedge clk) begin
    if (wren_b) mem_b[address_b] <= data_b;
    pipe_b[0] <= mem_b[address_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    if (wren_b) wr_cnt_b <= wr_cnt_b + 1;
  end
  assign q_b = pipe_b[LAT_B-1];

  always @(posedge clk) begin
    if (preload_c) begin
      for (int n = 0; n < 256; n++) mem_c[n] <= 8'(255 - n);
    end else if (wren_c) begin
      mem_c[address_c] <= data_c;
    end
    pipe_c[0] <= mem_c[address_c];
    pipe_c[1] <= pipe_c[0];
    pipe_c[2] <= pipe_c[1];
    if (wren_c) wr_cnt_c <= wr_cnt_c + 1;
    // Back-to-back writes to one address only occur as a WR_J/WR_I pair with i==j.
    if (wren_c && prev_wren_c && (address_c == prev_addr_c)) eq_cnt_c <= eq_cnt_c + 1;
    prev_wren_c <= wren_c;
    prev_addr_c <= address_c;
  end
  assign q_c = pipe_c[LAT_C-1];

  // ---------------- scoreboard helpers ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference KSA; key is right-aligned with byte 0 most significant.
  function automatic void ksa_model(input logic [255:0] key, input int nbytes, input bit init_fill);
    logic [7:0] j, t, kb;
    for (int n = 0; n < 256; n++) model_s[n] = init_fill ? 8'(n) : 8'(255 - n);
    j = 8'h00;
    model_eq = 0;
    for (int i = 0; i < 256; i++) begin
      kb = key[(nbytes - 1 - (i % nbytes)) * 8 +: 8];
      j = j + model_s[i] + kb;
      if (j == 8'(i)) model_eq++;
      t = model_s[i];
      model_s[i] = model_s[j];
      model_s[j] = t;
    end
  endfunction

  function automatic int count_diff(input logic [7:0] m [256]);
    int d = 0;
    for (int n = 0; n < 256; n++) if (m[n] !== model_s[n]) d++;
    return d;
  endfunction

  // First four keystream bytes produced from a scheduled S.
  function automatic logic [31:0] prga4(input logic [7:0] s_in [256]);
    logic [7:0] s [256];
    logic [7:0] i, j, t;
    logic [31:0] ks;
    s = s_in;
    i = 8'h00;
    j = 8'h00;
    ks = '0;
    for (int k = 0; k < 4; k++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i];
      s[i] = s[j];
      s[j] = t;
      ks = {ks[23:0], s[8'(s[i] + s[j])]};
    end
    return ks;
  endfunction

  function automatic bit done_sel(input int sel);
    case (sel)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  // Called right after the accepting edge's negedge; returns the edge index of done.
  task automatic wait_done(input int sel, input int limit, output int cyc);
    cyc = limit + 1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_sel(sel)) begin
        cyc = k;
        return;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int base;
    #1 reset = 1'b0;
    #1;
    check_eq("rst_bus_a", 32'({address_a, data_a}), 32'h0);
    check_eq("rst_ctl_a", 32'({wren_a, busy_a, done_a, aborted_a}), 32'h0);
    check_eq("rst_state_a", 32'(dbg_state_a), 32'(IDLE));
    preload_c = 1'b1;
    @(negedge clk);
    @(negedge clk);
    preload_c = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // Run a: known "Key" vector.
    ksa_model({232'h0, key_a}, 3, 1'b1);
    base = wr_cnt_a;
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    check_eq("a_busy_after_start", 32'(busy_a), 32'h1);
    check_eq("a_fill_first_write", 32'({wren_a, address_a, data_a}), 32'h10000);
    wait_done(0, 3000, cyc);
    check_eq("a_done_cycle", 32'(cyc), 32'd2561);
    check_eq("a_write_count", 32'(wr_cnt_a - base), 32'd768);
    check_eq("a_s_diff", 32'(count_diff(mem_a)), 32'd0);
    check_eq("a_keystream", prga4(mem_a), 32'hEB9F7781);
    @(posedge clk);
    @(negedge clk);
    check_eq("a_done_pulse_end", 32'({done_a, busy_a}), 32'h0);

    // Run b: start held high through the run and past completion.
    ksa_model({216'h0, key_b}, 5, 1'b1);
    base = wr_cnt_b;
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(1, 3000, cyc);
    check_eq("b_done_cycle", 32'(cyc), 32'd2049);
    check_eq("b_write_count", 32'(wr_cnt_b - base), 32'd768);
    check_eq("b_s_diff", 32'(count_diff(mem_b)), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("b_restart_busy", 32'({busy_b, dbg_state_b}), 32'({1'b1, FILL}));
    start_b = 1'b0;
    abort_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("b_abort_pulse", 32'({aborted_b, done_b, busy_b, wren_b}), 32'h8);
    @(posedge clk);
    @(negedge clk);
    abort_b = 1'b0;
    check_eq("b_abort_idle_ignored", 32'({aborted_b, busy_b}), 32'h0);

    // Run c: no fill, reversed preload, single zero key byte.
    ksa_model(256'h0, 1, 1'b0);
    base = wr_cnt_c;
    start_c = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_c = 1'b0;
    check_eq("c_first_state", 32'({wren_c, dbg_state_c}), 32'(RD_I));
    wait_done(2, 3500, cyc);
    check_eq("c_done_cycle", 32'(cyc), 32'd2817);
    check_eq("c_write_count", 32'(wr_cnt_c - base), 32'd512);
    check_eq("c_s_diff", 32'(count_diff(mem_c)), 32'd0);
    check_eq("c_i_eq_j_seen", 32'(eq_cnt_c > 0), 32'h1);
    check_eq("c_i_eq_j_count", 32'(eq_cnt_c), 32'(model_eq));

    // Abort a during the second WAIT_J cycle of iteration 100 (edge 256+900+6).
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 1; k <= 1161; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("a_in_wait_j", 32'(dbg_state_a), 32'(WAIT_J));
    abort_a = 1'b1;
    base = done_cnt_a;
    @(posedge clk);
    @(negedge clk);
    abort_a = 1'b0;
    check_eq("a_abort_pulse", 32'({aborted_a, done_a, busy_a, wren_a}), 32'h8);
    check_eq("a_abort_state", 32'(dbg_state_a), 32'(IDLE));
    cyc = wr_cnt_a;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("a_abort_no_writes", 32'(wr_cnt_a - cyc), 32'd0);
    check_eq("a_abort_no_done", 32'(done_cnt_a - base), 32'd0);
    check_eq("a_abort_pulse_end", 32'(aborted_a), 32'h0);

    // Reset a while it is filling.
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("a_filling", 32'({wren_a, busy_a, address_a}), 32'h332);
    #2 reset = 1'b0;
    #1;
    check_eq("midrst_bus_a", 32'({address_a, data_a}), 32'h0);
    check_eq("midrst_ctl_a", 32'({wren_a, busy_a, done_a, aborted_a}), 32'h0);
    check_eq("midrst_state_a", 32'(dbg_state_a), 32'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    cyc = wr_cnt_a;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("postrst_idle_a", 32'({wr_cnt_a - cyc, 4'(dbg_state_a)}), 32'(IDLE));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rc4_ksa_engine.md
RC4_KSA_ENGINE -- requirements
Module: rc4_ksa_engine

Interface
REQ-001 Parameter KEY_BYTES, default 3, key length in bytes; legal range 1..32.
REQ-002 Parameter RD_LAT, default 2, S-RAM read latency in cycles from address to valid q; legal range 1..3.
REQ-003 Parameter INIT_EN, default 1; 1 = engine performs S[n]=n fill before shuffle, 0 = shuffle only.
REQ-004 Derived constant KEY_W = 8*KEY_BYTES.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  begin a run; sampled only in IDLE.
REQ-008 abort  in  1  cancel the current run.
REQ-009 secret_key  in  KEY_W  key; byte 0 = secret_key[KEY_W-1 -: 8]; must stay stable while busy.
REQ-010 q  in  8  S-RAM read data.
REQ-011 address  out  8  S-RAM address.
REQ-012 data  out  8  S-RAM write data.
REQ-013 wren  out  1  S-RAM write enable; reads are implied whenever wren=0.
REQ-014 busy  out  1  high from the cycle after start acceptance until return to IDLE.
REQ-015 done  out  1  one-cycle pulse on successful completion.
REQ-016 aborted  out  1  one-cycle pulse when a run is cancelled by abort.

Function
REQ-017 States SHALL be IDLE, FILL, RD_I, WAIT_I, CALC_J, RD_J, WAIT_J, WR_J, WR_I, DONE.
REQ-018 IDLE: start=1 -> FILL if INIT_EN=1, else RD_I; i, j, and key index reset to 0 on acceptance.
REQ-019 FILL: one write per cycle (address=n, data=n, wren=1) for n=0..255, i.e. 256 cycles, then RD_I.
REQ-020 RD_I: address=i, wren=0 for 1 cycle; WAIT_I holds for RD_LAT cycles and captures si=q in its last cycle.
REQ-021 CALC_J: j <= (j + si + key[i mod KEY_BYTES]) mod 256 in 1 cycle.
REQ-022 Key index SHALL be a wrapping counter 0..KEY_BYTES-1, advanced with i; no divide/modulo operator.
REQ-023 RD_J: address=j, wren=0 for 1 cycle; WAIT_J holds RD_LAT cycles and captures sj.
REQ-024 WR_J: address=j, data=si, wren=1 (1 cycle); WR_I: address=i, data=sj, wren=1 (1 cycle).
REQ-025 Each iteration SHALL take exactly 5+2*RD_LAT cycles; after WR_I with i=255 -> DONE, else i+1 and RD_I.
REQ-026 i==j: both writes hit the same address with an identical value; no special case required.
REQ-027 DONE: done=1 for exactly 1 cycle, wren=0, then IDLE.
REQ-028 Completion: done high exactly INIT_EN*256 + 256*(5+2*RD_LAT) + 1 cycles after the start-accepting edge.
REQ-029 abort in any non-IDLE state: next edge -> IDLE, wren=0, aborted=1 for 1 cycle, done not asserted.
REQ-030 abort has priority over start and over the DONE transition; abort in IDLE is ignored.
REQ-031 start while busy SHALL be ignored; start held high in IDLE after completion begins a new run.
REQ-032 wren SHALL be 0 in IDLE, RD_*, WAIT_*, CALC_J, DONE.

Reset
REQ-033 reset low: state=IDLE, address=0, data=0, wren=0, busy=0, done=0, aborted=0, i=j=0, immediately and asynchronously.
REQ-034 reset mid-run: no further writes issue; S-RAM content is undefined; a fresh start is required.

Structure
REQ-035 Package rc4_pkg holds the state enum, S_SIZE=256, and the key-byte width constant.
REQ-036 One sub-module, key_byte_sel (parametrised by KEY_BYTES), maps key index -> 8-bit key byte.

Verification
REQ-037 KEY_BYTES=3, RD_LAT=2, INIT_EN=1, key 0x4B6579 -> S-RAM matches software KSA model; done at cycle 2561.
REQ-038 KEY_BYTES=5, RD_LAT=1, key 0x0102030405 -> S matches model; done at 256+1792+1=2049 cycles.
REQ-039 INIT_EN=0, RAM preloaded S[n]=255-n, key 0x000000 -> S matches model; no FILL writes observed.
REQ-040 abort asserted during iteration 100 WAIT_J -> aborted pulse next cycle, wren=0 from that cycle on, no done.
REQ-041 start pulsed while busy, and reset asserted during FILL -> start ignored; after reset all outputs 0 immediately, state IDLE.
REQ-042 Key 0x000000, KEY_BYTES=1 -> at least one iteration with i==j observed; S still matches model.
